// File: rtl/life_gen_engine_if.sv
// Bundles the engine's control handshake and the grid memory selector port.
// master = life_gen_engine side, slave = controller/memory side.
interface life_gen_engine_if #(
  parameter int COLS   = 16,
  parameter int ADDR_W = 2
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic              stable;
  logic [ADDR_W-1:0] array_selector;
  logic              write_enb;
  logic [COLS-1:0]   alive_in_selector;
  logic [COLS-1:0]   alive_out_selector;

  modport master (
    input  start, alive_out_selector,
    output busy, done, stable, array_selector, write_enb, alive_in_selector
  );

  modport slave (
    output start, alive_out_selector,
    input  busy, done, stable, array_selector, write_enb, alive_in_selector
  );
endinterface

// File: rtl/life_gen_engine.sv
// Game-of-Life generation stepper: reads all rows, writes the B3/S23 successor back.
// Define LIFE_TORUS_EN for a toroidal grid; otherwise cells beyond the edge are dead.
module life_gen_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 16,
  parameter int ADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  life_gen_engine_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ONE_ROW  = ADDR_W'(1);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] cnt_r, cnt_s;
  logic [COLS-1:0]   row_buf_r [ROWS];
  logic              changed_r, changed_s;
  logic              busy_r, done_r, stable_r, write_enb_r;
  logic [ADDR_W-1:0] sel_r;
  logic [COLS-1:0]   up_s, dn_s, cur_s, next_row_s;

  // bit c of the result holds x[c-1]
  function automatic logic [COLS-1:0] from_left(input logic [COLS-1:0] x);
`ifdef LIFE_TORUS_EN
    return {x[COLS-2:0], x[COLS-1]};
`else
    return {x[COLS-2:0], 1'b0};
`endif
  endfunction

  // bit c of the result holds x[c+1]
  function automatic logic [COLS-1:0] from_right(input logic [COLS-1:0] x);
`ifdef LIFE_TORUS_EN
    return {x[0], x[COLS-1:1]};
`else
    return {1'b0, x[COLS-1:1]};
`endif
  endfunction

  // B3/S23 successor of the middle row given its vertical neighbours
  function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] up,
                                               input logic [COLS-1:0] cur,
                                               input logic [COLS-1:0] dn);
    logic [COLS-1:0] ul, ur, cl, cr, dl, dr, res;
    logic [3:0]      nb;
    ul = from_left(up);  ur = from_right(up);
    cl = from_left(cur); cr = from_right(cur);
    dl = from_left(dn);  dr = from_right(dn);
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      nb = {3'b000, ul[c]} + {3'b000, up[c]} + {3'b000, ur[c]} +
           {3'b000, cl[c]} + {3'b000, cr[c]} +
           {3'b000, dl[c]} + {3'b000, dn[c]} + {3'b000, dr[c]};
      res[c] = (nb == 4'd3) || (cur[c] && (nb == 4'd2));
    end
    return res;
  endfunction

  // neighbour rows of the row being written; only the old generation in row_buf_r is used
  always_comb begin
    cur_s = row_buf_r[cnt_r];
    up_s  = row_buf_r[cnt_r - ONE_ROW];
    dn_s  = row_buf_r[cnt_r + ONE_ROW];
`ifndef LIFE_TORUS_EN
    if (cnt_r == '0) begin
      up_s = '0;
    end else begin
      up_s = row_buf_r[cnt_r - ONE_ROW];
    end
    if (cnt_r == LAST_ROW) begin
      dn_s = '0;
    end else begin
      dn_s = row_buf_r[cnt_r + ONE_ROW];
    end
`endif
    next_row_s = life_row(up_s, cur_s, dn_s);
  end

  // next state, row counter and sticky change flag
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    changed_s = changed_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_READ;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        cnt_s = cnt_r + ONE_ROW;
        if (cnt_r == LAST_ROW) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        state_s = ST_WRITE;
        cnt_s   = '0;
      end
      ST_WRITE: begin
        cnt_s = cnt_r + ONE_ROW;
        if (next_row_s != cur_s) begin
          changed_s = 1'b1;
        end else begin
          changed_s = changed_r;
        end
        if (cnt_r == LAST_ROW) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        changed_s = 1'b0;
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        changed_s = 1'b0;
      end
    endcase
  end

  // state registers and control outputs, registered from the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      changed_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      stable_r    <= 1'b0;
      write_enb_r <= 1'b0;
      sel_r       <= '0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      changed_r   <= changed_s;
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      stable_r    <= (state_s == ST_DONE) && !changed_s;
      write_enb_r <= (state_s == ST_WRITE);
      sel_r       <= ((state_s == ST_READ) || (state_s == ST_WRITE)) ? cnt_s : '0;
    end
  end

  // memory data arrives one cycle after its row was selected, hence the lagging index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        row_buf_r[r] <= '0;
      end
    end else if ((state_r == ST_READ) && (cnt_r != '0)) begin
      row_buf_r[cnt_r - ONE_ROW] <= bus.alive_out_selector;
    end else if (state_r == ST_DRAIN) begin
      row_buf_r[LAST_ROW] <= bus.alive_out_selector;
    end else begin
      row_buf_r <= row_buf_r;
    end
  end

  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.stable            = stable_r;
  assign bus.write_enb         = write_enb_r;
  assign bus.array_selector    = sel_r;
  assign bus.alive_in_selector = write_enb_r ? next_row_s : '0;

endmodule

// File: tb/tb_life_gen_engine.sv
// Directed bench for life_gen_engine with a registered-read grid memory model.
module tb_life_gen_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] mem [4];
  logic        load_en = 1'b0;
  logic [63:0] load_rows = 64'd0;

  life_gen_engine_if #(.COLS(16), .ADDR_W(2)) bus ();

  life_gen_engine #(.ROWS(4), .COLS(16), .ADDR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) begin
      for (int r = 0; r < 4; r++) mem[r] <= load_rows[r*16 +: 16];
    end else if (bus.write_enb) begin
      mem[bus.array_selector] <= bus.alive_in_selector;
    end
    bus.alive_out_selector <= mem[bus.array_selector];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input logic [63:0] rows);
    load_rows = rows;
    load_en   = 1'b1;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // One step starting at a negedge; checks every cycle 1..14 against the fixed schedule.
  task automatic run_step(input string tag, input logic [63:0] exp_rows,
                          input logic exp_stable, input int poke_a, input int poke_b);
    logic [15:0] exp_data;
    logic [1:0]  exp_sel;
    bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_sel  = 2'd0;
      exp_data = 16'h0000;
      if (k >= 1 && k <= 4) exp_sel = 2'(k - 1);
      if (k >= 6 && k <= 9) begin
        exp_sel  = 2'(k - 6);
        exp_data = exp_rows[(k-6)*16 +: 16];
      end
      chk({tag, ".busy"}, 64'(bus.busy), 64'(k <= 10));
      chk({tag, ".we"},   64'(bus.write_enb), 64'(k >= 6 && k <= 9));
      chk({tag, ".sel"},  64'(bus.array_selector), 64'(exp_sel));
      chk({tag, ".data"}, 64'(bus.alive_in_selector), 64'(exp_data));
      chk({tag, ".done"}, 64'(bus.done), 64'(k == 10));
      if (k == 10) chk({tag, ".stable"}, 64'(bus.stable), 64'(exp_stable));
      bus.start = (k == poke_a) || (k == poke_b);
    end
    chk({tag, ".mem"}, {mem[3], mem[2], mem[1], mem[0]}, exp_rows);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.we",   64'(bus.write_enb), 64'd0);
    chk("rst.sel",  64'(bus.array_selector), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // blinker, two steps; no wrap interaction so both builds agree
    load_mem(64'h0000_0000_0070_0000);
    run_step("blink1", 64'h0000_0020_0020_0020, 1'b0, 0, 0);
    run_step("blink2", 64'h0000_0000_0070_0000, 1'b0, 0, 0);

    // still-life block
    load_mem(64'h0000_0180_0180_0000);
    run_step("block", 64'h0000_0180_0180_0000, 1'b1, 0, 0);

    // start pulses during an active step must be dropped
    run_step("poke", 64'h0000_0180_0180_0000, 1'b1, 3, 8);

    // start held: back-to-back steps every 11 cycles
    bus.start = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      chk("held.done", 64'(bus.done), 64'((k % 11 == 10) && (k <= 32)));
      chk("held.busy", 64'(bus.busy), 64'((k % 11 != 0) && (k <= 32)));
      chk("held.we",   64'(bus.write_enb),
          64'((k % 11 >= 6) && (k % 11 <= 9) && (k <= 31)));
      if ((k % 11 == 10) && (k <= 32)) chk("held.stable", 64'(bus.stable), 64'd1);
      bus.start = (k < 32);
    end

    // horizontal blinker straddling column 15/0
    load_mem(64'h0000_0000_8003_0000);
`ifdef LIFE_TORUS_EN
    run_step("wrap", 64'h0000_0001_0001_0001, 1'b0, 0, 0);
`else
    run_step("wrap", 64'h0000_0000_0000_0000, 1'b0, 0, 0);
`endif

    // reset after the second row write
    load_mem(64'h0000_0000_0070_0000);
    bus.start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.we",   64'(bus.write_enb), 64'd0);
    chk("arst.busy", 64'(bus.busy), 64'd0);
    chk("arst.done", 64'(bus.done), 64'd0);
    chk("arst.sel",  64'(bus.array_selector), 64'd0);
    @(negedge clk);
    chk("arst.mem", {mem[3], mem[2], mem[1], mem[0]}, 64'h0000_0000_0020_0020);
    rst_n = 1'b1;
    @(negedge clk);
    run_step("after", 64'h0000_0000_0000_0000, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
